// File: rtl/tof_burst_gen.sv
// ToF modulation burst sequencer: warm-up flush, square-wave burst and tail flush per frame.
// Define TOF_BURST_MULTIPHASE_EN to repeat the sequence PHASES times per frame with a phase index.
module tof_burst_gen #(
  parameter int HALF_PERIOD = 4,
  parameter int WARMUP      = 16,
  parameter int TAIL        = 8,
  parameter int PHASES      = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pulse_count,
  output logic             busy,
  output logic             mod_out,
  output logic             shift_we,
  output logic [1:0]       phase_idx,
  output logic             frame_done
);

  localparam int HALF_W  = $clog2(HALF_PERIOD + 1);
  localparam int SEG_MAX = (WARMUP > TAIL) ? WARMUP : TAIL;
  localparam int SEG_W   = $clog2(SEG_MAX + 1);

  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(HALF_PERIOD - 1);
  localparam logic [SEG_W-1:0]  WARM_LOAD = SEG_W'(WARMUP - 1);
  localparam logic [SEG_W-1:0]  TAIL_LOAD = SEG_W'(TAIL - 1);
  localparam logic [SEG_W-1:0]  SEG_ONE   = SEG_W'(1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [CNT_W-1:0]  PULSE_ONE = CNT_W'(1);

  if (HALF_PERIOD < 1 || WARMUP < 1 || TAIL < 1 || PHASES < 1 || PHASES > 4 || CNT_W < 1)
  begin : g_param_check
    $error("tof_burst_gen: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_BURST,
    S_TAIL
  } state_t;

  state_t            state_q, state_d;
  logic [SEG_W-1:0]  seg_q, seg_d;     // cycles left in WARMUP/TAIL after this one
  logic [HALF_W-1:0] half_q, half_d;   // cycles left in the current half period
  logic [CNT_W-1:0]  pulse_q, pulse_d; // periods left in the burst, including this one
  logic [CNT_W-1:0]  lat_q, lat_d;     // pulse_count captured at the accepted start
  logic              busy_d, mod_d, we_d, done_d;
  logic              last_phase;

`ifdef TOF_BURST_MULTIPHASE_EN
  localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);
  logic [1:0] phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= 2'b00;
    else        phase_q <= phase_d;
  end

  assign last_phase = (phase_q == LAST_PHASE);
  assign phase_idx  = phase_q;
`else
  assign last_phase = 1'b1;
  assign phase_idx  = 2'b00;
`endif

  // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    half_d  = half_q;
    pulse_d = pulse_q;
    lat_d   = lat_q;
    busy_d  = busy;
    mod_d   = mod_out;
    we_d    = shift_we;
    done_d  = 1'b0;
`ifdef TOF_BURST_MULTIPHASE_EN
    phase_d = phase_q;
`endif

    if (abort) begin
      state_d = S_IDLE;
      seg_d   = '0;
      half_d  = '0;
      pulse_d = '0;
      lat_d   = '0;
      busy_d  = 1'b0;
      mod_d   = 1'b0;
      we_d    = 1'b0;
`ifdef TOF_BURST_MULTIPHASE_EN
      phase_d = 2'b00;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
          mod_d  = 1'b0;
          we_d   = 1'b0;
          if (start) begin
            state_d = S_WARMUP;
            seg_d   = WARM_LOAD;
            lat_d   = pulse_count;
            busy_d  = 1'b1;
            we_d    = 1'b1;
`ifdef TOF_BURST_MULTIPHASE_EN
            phase_d = 2'b00;
`endif
          end
        end

        S_WARMUP: begin
          if (seg_q != '0) begin
            seg_d = seg_q - SEG_ONE;
          end else if (lat_q == '0) begin
            state_d = S_TAIL;
            seg_d   = TAIL_LOAD;
          end else begin
            state_d = S_BURST;
            half_d  = HALF_LOAD;
            pulse_d = lat_q;
            mod_d   = 1'b1;
          end
        end

        S_BURST: begin
          // mod_out itself tells which half of the period is running.
          if (half_q != '0) begin
            half_d = half_q - HALF_ONE;
          end else if (mod_out) begin
            half_d = HALF_LOAD;
            mod_d  = 1'b0;
          end else if (pulse_q == PULSE_ONE) begin
            state_d = S_TAIL;
            seg_d   = TAIL_LOAD;
            pulse_d = '0;
          end else begin
            half_d  = HALF_LOAD;
            pulse_d = pulse_q - PULSE_ONE;
            mod_d   = 1'b1;
          end
        end

        S_TAIL: begin
          if (seg_q != '0) begin
            seg_d = seg_q - SEG_ONE;
          end else if (!last_phase) begin
            state_d = S_WARMUP;
            seg_d   = WARM_LOAD;
`ifdef TOF_BURST_MULTIPHASE_EN
            phase_d = phase_q + 2'd1;
`endif
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      seg_q      <= '0;
      half_q     <= '0;
      pulse_q    <= '0;
      lat_q      <= '0;
      busy       <= 1'b0;
      mod_out    <= 1'b0;
      shift_we   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      half_q     <= half_d;
      pulse_q    <= pulse_d;
      lat_q      <= lat_d;
      busy       <= busy_d;
      mod_out    <= mod_d;
      shift_we   <= we_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_tof_burst_gen.sv
// Self-checking bench for tof_burst_gen: table-driven frame checkpoints plus full-frame sweeps
// against a cycle model, and hand-written abort/reset/restart sequences.
module tb_tof_burst_gen;

  localparam int HALF    = 4;
  localparam int WARMUP  = 16;
  localparam int TAIL    = 8;
  localparam int PHASES  = 4;
  localparam int CNT_W   = 16;
`ifdef TOF_BURST_MULTIPHASE_EN
  localparam int NPH = PHASES;
`else
  localparam int NPH = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] pulse_count = '0;
  logic             busy, mod_out, shift_we, frame_done;
  logic [1:0]       phase_idx;

  tof_burst_gen #(
    .HALF_PERIOD(HALF), .WARMUP(WARMUP), .TAIL(TAIL), .PHASES(PHASES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pulse_count(pulse_count),
    .busy(busy), .mod_out(mod_out), .shift_we(shift_we), .phase_idx(phase_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation word: {busy, mod_out, shift_we, frame_done, phase_idx[1:0]}
  logic [5:0] tr [0:255];

  typedef struct {
    int         n;
    int         cyc;
    logic [5:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {busy,mod,we,done,ph}=%b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {busy, mod_out, shift_we, frame_done, phase_idx};
  endfunction

  function automatic int frame_len(input int n);
    return NPH * (WARMUP + 2 * HALF * n + TAIL);
  endfunction

  // Spec-level model of one frame, cycle 1 being the first cycle after the accepted start.
  function automatic logic [5:0] exp_at(input int c, input int n);
    int   l;
    int   p;
    int   o;
    logic m;
    l = WARMUP + 2 * HALF * n + TAIL;
    if (c >= 1 && c <= NPH * l) begin
      p = (c - 1) / l;
      o = (c - 1) % l + 1;
      m = (o > WARMUP) && (o <= WARMUP + 2 * HALF * n) && (((o - WARMUP - 1) % (2 * HALF)) < HALF);
      return {1'b1, m, 1'b1, 1'b0, 2'(p)};
    end
    if (c == NPH * l + 1) return 6'b000100;
    return 6'b000000;
  endfunction

  // Starts a frame with count n and records ncyc cycles; optionally pulses start (with
  // count inj_n) at cycle inj_cycle and abort at cycle abort_cycle.
  task automatic run_frame(input int n, input int inj_cycle, input int inj_n,
                           input int abort_cycle, input int ncyc);
    @(negedge clk);
    start       = 1'b1;
    abort       = 1'b0;
    pulse_count = CNT_W'(n);
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      tr[c] = obs();
      start = (c == inj_cycle);
      abort = (c == abort_cycle);
      if (c == inj_cycle) pulse_count = CNT_W'(inj_n);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic sweep(input string tag, input int n, input int from, input int to);
    for (int c = from; c <= to; c++)
      check($sformatf("%s_c%0d", tag, c), tr[c], exp_at(c, n));
  endtask

  initial begin
    vec_t vecs[$];
    int   ns[2];
    int   fl;

    // N=3 checkpoints (hand-computed)
    vecs.push_back('{3,  1, 6'b101000});
    vecs.push_back('{3, 16, 6'b101000});
    vecs.push_back('{3, 17, 6'b111000});
    vecs.push_back('{3, 20, 6'b111000});
    vecs.push_back('{3, 21, 6'b101000});
    vecs.push_back('{3, 24, 6'b101000});
    vecs.push_back('{3, 25, 6'b111000});
    vecs.push_back('{3, 33, 6'b111000});
    vecs.push_back('{3, 36, 6'b111000});
    vecs.push_back('{3, 37, 6'b101000});
    vecs.push_back('{3, 48, 6'b101000});
`ifdef TOF_BURST_MULTIPHASE_EN
    vecs.push_back('{3,  49, 6'b101001});
    vecs.push_back('{3,  65, 6'b111001});
    vecs.push_back('{3,  96, 6'b101001});
    vecs.push_back('{3,  97, 6'b101010});
    vecs.push_back('{3, 145, 6'b101011});
    vecs.push_back('{3, 192, 6'b101011});
    vecs.push_back('{3, 193, 6'b000100});
    vecs.push_back('{3, 194, 6'b000000});
`else
    vecs.push_back('{3, 49, 6'b000100});
    vecs.push_back('{3, 50, 6'b000000});
`endif
    // N=0 checkpoints
    vecs.push_back('{0,  1, 6'b101000});
    vecs.push_back('{0, 17, 6'b101000});
    vecs.push_back('{0, 24, 6'b101000});
`ifdef TOF_BURST_MULTIPHASE_EN
    vecs.push_back('{0, 25, 6'b101001});
    vecs.push_back('{0, 96, 6'b101011});
    vecs.push_back('{0, 97, 6'b000100});
`else
    vecs.push_back('{0, 25, 6'b000100});
    vecs.push_back('{0, 26, 6'b000000});
`endif

    // Reset and idle
    repeat (3) @(negedge clk);
    check("reset", obs(), 6'b000000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", obs(), 6'b000000);

    // Table-driven checkpoints plus full sweeps for each count
    ns[0] = 3;
    ns[1] = 0;
    foreach (ns[k]) begin
      fl = frame_len(ns[k]);
      run_frame(ns[k], 0, 0, 0, fl + 3);
      for (int i = 0; i < vecs.size(); i++)
        if (vecs[i].n == ns[k])
          check($sformatf("vec_n%0d_c%0d", vecs[i].n, vecs[i].cyc), tr[vecs[i].cyc], vecs[i].exp);
      sweep($sformatf("sweep_n%0d", ns[k]), ns[k], 1, fl + 3);
    end

    // Start (with a different count) while busy: frame unchanged, still N=3
    fl = frame_len(3);
    run_frame(3, 10, 7, 0, fl + 3);
    sweep("start_busy", 3, 1, fl + 3);

    // Start in the frame_done cycle is accepted immediately
    fl = frame_len(0);
    run_frame(0, fl + 1, 0, 0, fl + 2);
    check("restart_done_cycle", tr[fl + 1], 6'b000100);
    check("restart_first_cycle", tr[fl + 2], 6'b101000);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cleanup", obs(), 6'b000000);

    // Abort at cycle 20: idle from cycle 21, no frame_done afterwards
    run_frame(3, 0, 0, 20, 60);
    sweep("pre_abort", 3, 1, 20);
    for (int c = 21; c <= 60; c++)
      check($sformatf("post_abort_c%0d", c), tr[c], 6'b000000);

    // start and abort together in IDLE: stays idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    pulse_count = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("start_abort_idle_%0d", c), obs(), 6'b000000);
      @(negedge clk);
    end

    // Asynchronous reset mid-burst, then 20 idle cycles
    run_frame(3, 0, 0, 0, 25);
    check("pre_reset_burst", tr[25], 6'b111000);
    rst_n = 1'b0;
    #1;
    check("reset_mid_burst", obs(), 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle_hold_%0d", c), obs(), 6'b000000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tof_burst_gen.md
# tof_burst_gen

Modulation burst sequencer for the ToF illumination path. It generates the square-wave modulation bitstream that feeds the per-bit shift-register delay line, and the shift-enable strobe for that line. The delay line turns the stream into phase-shifted sensor gates. One start request produces one frame: warm-up flush, a modulation burst and a tail flush, repeated per phase when multiphase is compiled in.

## Interface
- HALF_PERIOD, 4: clk cycles per modulation half period; ≥1.
- WARMUP, 16: zero-fill cycles before each burst; ≥1. Covers the longest downstream delay.
- TAIL, 8: zero-fill cycles after each burst; ≥1.
- PHASES, 4: sub-bursts per frame when multiphase is enabled; 1..4.
- CNT_W, 16: width of the pulse counter.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request; only acted on in IDLE.
- abort  in  1  synchronous frame cancel; acted on in any state.
- pulse_count  in  CNT_W  modulation periods per burst; latched at the accepted start.
- busy  out  1  high from the cycle after an accepted start until frame end.
- mod_out  out  1  modulation bit, feeds delay-line data_in.
- shift_we  out  1  delay-line write enable.
- phase_idx  out  2  current phase index.
- frame_done  out  1  one-cycle pulse at normal frame completion.

## Operation
- States: IDLE, WARMUP, BURST, TAIL. All outputs are registered.
- IDLE:
  - busy=0, shift_we=0, mod_out=0.
  - start=1 and abort=0 → latch pulse_count, clear phase_idx, go to WARMUP.
- WARMUP:
  - Lasts WARMUP cycles with mod_out=0 and shift_we=1, flushing the delay line with zeros.
  - Then go to BURST, or straight to TAIL if the latched count is 0.
- BURST:
  - shift_we=1.
  - Each period is mod_out=1 for HALF_PERIOD cycles, then mod_out=0 for HALF_PERIOD cycles.
  - Runs for exactly N periods, N being the latched count, then goes to TAIL.
- TAIL:
  - Lasts TAIL cycles with mod_out=0 and shift_we=1.
  - Then, if more phases remain: phase_idx+1 and go to WARMUP. Otherwise go to IDLE.
- On the TAIL→IDLE transition, frame_done=1 for one cycle while busy=0 in the same cycle.
- start while busy: ignored. pulse_count changes while busy: ignored.
- abort=1, any state:
  - Next cycle is IDLE with all outputs at reset values.
  - No frame_done is issued.
  - abort wins over a simultaneous start.
- Counters:
  - Half-period counter width is $clog2(HALF_PERIOD+1).
  - Pulse counter width is CNT_W. It never wraps, and pulse_count = 2^CNT_W−1 is legal.
- Reset (rst_n=0): state=IDLE, busy=0, mod_out=0, shift_we=0, phase_idx=0, frame_done=0, counters=0. Reset mid-frame has the same effect immediately.

## Timing
- An accepted start sampled at edge 0 gives, in cycle 1: busy=1, shift_we=1, mod_out=0.
- One phase lasts L = WARMUP + 2·HALF_PERIOD·N + TAIL cycles.
- The first mod_out=1 appears in cycle WARMUP+1.
- Single phase: busy is high in cycles 1..L, and frame_done is high in cycle L+1.
- Multiphase: phases run back to back with no idle gap. phase_idx changes in the first WARMUP cycle of each new phase.
- Frame length is PHASES·L, with frame_done in cycle PHASES·L+1.
- A start in the frame_done cycle (IDLE) is accepted, so a new frame begins the next cycle.
- shift_we is never high while busy=0.

## Configuration
- TOF_BURST_MULTIPHASE_EN defined: a frame is PHASES sub-bursts, and phase_idx counts 0..PHASES−1.
- Not defined: a frame is one burst, phase_idx is tied to 0, PHASES is ignored and no phase counter is built.

## Test plan
- Reset and IDLE:
  - Stimulus: assert rst_n=0 mid-burst and release; then hold start=0 for 20 cycles.
  - Response: all outputs 0 and stay 0.
- Single phase (macro off), HALF_PERIOD=4, WARMUP=16, TAIL=8, pulse_count=3:
  - busy high cycles 1..48.
  - mod_out=1 in cycles 17–20, 25–28 and 33–36.
  - frame_done pulses at cycle 49.
- Multiphase (macro on), PHASES=4, same parameters:
  - phase_idx goes 0,1,2,3, changing at cycles 49, 97 and 145.
  - frame_done pulses at cycle 193.
- pulse_count=0:
  - mod_out stays 0.
  - busy lasts WARMUP+TAIL=24 cycles, then frame_done.
- Abort and simultaneous requests:
  - abort at cycle 20 → busy=0 and shift_we=0 at cycle 21, with no frame_done.
  - start and abort together in IDLE → stays IDLE.
- Start while busy:
  - Stimulus: pulse start at cycle 10 with pulse_count=7.
  - Response: frame timing is unchanged and still uses N=3.
